// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM array: mode encodings, pattern FSM states
// and small width helpers used by the top and the tick generator.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_CHASE  = 2'd1,
    ST_BRE_UP = 2'd2,
    ST_BRE_DN = 2'd3
  } pat_state_e;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The reserved encoding behaves exactly like STATIC.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_CHASE;
      2'd2:    return MODE_BREATHE;
      default: return MODE_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm_tick_gen.sv
// Prescaler and PWM frame counter; flags the frame boundary (tick on the last
// count of the frame) with a single-clock frame_pulse.
module led_pwm_tick_gen
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 256
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_pulse
);

  localparam int PS_W = width_of(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     prescale_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                tick;

  // Gated by reset so no spurious boundary is seen while reset is held.
  assign tick        = !reset && (prescale_reg == PS_LAST);
  assign frame_pulse = tick && (pwm_cnt_reg == {PWM_BITS{1'b1}});
  assign pwm_cnt     = pwm_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_reg <= '0;
      pwm_cnt_reg  <= '0;
    end else begin
      if (tick) begin
        prescale_reg <= '0;
        pwm_cnt_reg  <= pwm_cnt_reg + PWM_BITS'(1);
      end else begin
        prescale_reg <= prescale_reg + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm_array.sv
// N-channel LED PWM driver: host-written shadow duties, frame-synchronous
// active duties driven by a static / chase / breathe pattern engine.
module led_pwm_array
  import led_pwm_pkg::*;
#(
  parameter int N_CH            = 8,
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 256,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(N_CH)-1:0]  wr_addr,
  input  logic [PWM_BITS-1:0]      wr_data,
  input  logic [1:0]               mode,
  output logic [N_CH-1:0]          led,
  output logic                     frame_pulse
);

  localparam int ADDR_W = $clog2(N_CH);
  localparam int STEP_W = width_of(FRAMES_PER_STEP);
  localparam logic [ADDR_W:0]       N_CH_EXT  = (ADDR_W + 1)'(N_CH);
  localparam logic [ADDR_W-1:0]     IDX_LAST  = ADDR_W'(N_CH - 1);
  localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [PWM_BITS-1:0]   DUTY_MAX  = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                boundary;

  logic [PWM_BITS-1:0] shadow_reg  [N_CH];
  logic [PWM_BITS-1:0] active_reg  [N_CH];
  logic [PWM_BITS-1:0] active_next [N_CH];

  pat_state_e          state_reg, state_next;
  mode_e               mode_reg, mode_next, mode_in;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic [PWM_BITS-1:0] ramp_reg, ramp_next;
  logic [STEP_W-1:0]   step_cnt_reg, step_cnt_next;

  logic [N_CH-1:0]     led_on;
  logic [N_CH-1:0]     led_reg;
  logic                wr_ok;

  led_pwm_tick_gen #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .pwm_cnt     (pwm_cnt),
    .frame_pulse (boundary)
  );

  assign frame_pulse = boundary;
  assign mode_in     = decode_mode(mode);
  assign wr_ok       = wr_en && ({1'b0, wr_addr} < N_CH_EXT);

  // Shadow registers: out-of-range addresses simply match no channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) shadow_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_ok && (wr_addr == ADDR_W'(i))) shadow_reg[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_STATIC;
      mode_reg     <= MODE_STATIC;
      idx_reg      <= '0;
      ramp_reg     <= '0;
      step_cnt_reg <= '0;
      for (int i = 0; i < N_CH; i++) active_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      idx_reg      <= idx_next;
      ramp_reg     <= ramp_next;
      step_cnt_reg <= step_cnt_next;
      for (int i = 0; i < N_CH; i++) active_reg[i] <= active_next[i];
    end
  end

  // Pattern engine: everything moves only on the frame boundary clock.
  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    idx_next      = idx_reg;
    ramp_next     = ramp_reg;
    step_cnt_next = step_cnt_reg;
    active_next   = active_reg;

    if (boundary) begin
      if (mode_in != mode_reg) begin
        mode_next     = mode_in;
        step_cnt_next = '0;
        idx_next      = '0;
        ramp_next     = '0;
        case (mode_in)
          MODE_CHASE:   state_next = ST_CHASE;
          MODE_BREATHE: state_next = ST_BRE_UP;
          default:      state_next = ST_STATIC;
        endcase
      end else if (step_cnt_reg == STEP_LAST) begin
        step_cnt_next = '0;
        case (state_reg)
          ST_CHASE: idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + ADDR_W'(1);
          ST_BRE_UP: begin
            if (ramp_reg == DUTY_MAX) begin
              state_next = ST_BRE_DN;
              ramp_next  = DUTY_MAX - PWM_BITS'(1);
            end else begin
              ramp_next  = ramp_reg + PWM_BITS'(1);
            end
          end
          ST_BRE_DN: begin
            if (ramp_reg == '0) begin
              state_next = ST_BRE_UP;
              ramp_next  = PWM_BITS'(1);
            end else begin
              ramp_next  = ramp_reg - PWM_BITS'(1);
            end
          end
          default: ;
        endcase
      end else begin
        step_cnt_next = step_cnt_reg + STEP_W'(1);
      end

      // Duties follow the pattern state that takes effect on this boundary.
      for (int i = 0; i < N_CH; i++) begin
        case (state_next)
          ST_CHASE:             active_next[i] = (idx_next == ADDR_W'(i)) ? shadow_reg[i] : '0;
          ST_BRE_UP, ST_BRE_DN: active_next[i] = ramp_next;
          default:              active_next[i] = shadow_reg[i];
        endcase
      end
    end
  end

  // Full-scale duty is forced on so the LED never blinks off once per frame.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign led_on[gi] = (active_reg[gi] == DUTY_MAX) || (pwm_cnt < active_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (reset) led_reg <= '0;
    else       led_reg <= led_on;
  end

  assign led = led_reg;

endmodule

// File: tb/tb_led_pwm_array.sv
// Scoreboarded bench for led_pwm_array: per-clock expected LED vectors are
// queued per frame and compared against the DUT outputs.
module tb_led_pwm_array;

  localparam int FR = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] mode;
  logic [7:0] led;
  logic       frame_pulse;

  logic       wr_en6;
  logic [2:0] wr_addr6;
  logic [3:0] wr_data6;
  logic [1:0] mode6;
  logic [5:0] led6;
  logic       frame_pulse6;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  bit use6 = 1'b0;
  logic [7:0][3:0] sh8;
  logic [7:0][3:0] d6;

  led_pwm_array #(.N_CH(8), .PWM_BITS(4), .PRESCALE(1), .FRAMES_PER_STEP(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mode(mode), .led(led), .frame_pulse(frame_pulse)
  );

  led_pwm_array #(.N_CH(6), .PWM_BITS(4), .PRESCALE(1), .FRAMES_PER_STEP(1)) dut6 (
    .clk(clk), .reset(reset), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
    .mode(mode6), .led(led6), .frame_pulse(frame_pulse6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_frames(input int n, input logic [7:0][3:0] d);
    logic [7:0] b;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FR; c++) begin
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = (d[i] == 4'hF) || (c < int'(d[i]));
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_pulse(input bit chk, input logic [7:0] exp_led);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (chk) begin
        checks++;
        if (led !== exp_led) begin
          errors++;
          $display("FAIL hold_until_boundary: led=%h required %h", led, exp_led);
        end
      end
      if (frame_pulse) return;
    end
    checks++;
    errors++;
    $display("FAIL boundary_timeout: no frame_pulse in 40 clk, required one per %0d", FR);
  endtask

  // Call right after the negedge where frame_pulse was seen.
  task automatic check_frames(input int n);
    logic [7:0] e;
    logic [7:0] got;
    @(negedge clk);
    for (int j = 0; j < n * FR; j++) begin
      @(negedge clk);
      got = use6 ? {2'b00, led6} : led;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: led=%h required queued value", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL frame_led: frame %0d cnt %0d led=%h required %h", j / FR, j % FR, got, e);
        end
      end
    end
  endtask

  task automatic wr8(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] a, input logic [3:0] d);
    wr_en6 = 1'b1; wr_addr6 = a; wr_data6 = d;
    @(negedge clk);
    wr_en6 = 1'b0;
  endtask

  task automatic test_reset();
    int period;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL reset_led: led=%h required 00", led); end
    checks++;
    if (frame_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: frame_pulse=%b required 0", frame_pulse); end
    checks++;
    if (led6 !== 6'h00 || frame_pulse6 !== 1'b0) begin
      errors++; $display("FAIL reset_dut6: led6=%h pulse=%b required 00/0", led6, frame_pulse6);
    end
    reset = 1'b0;
    wait_pulse(1'b1, 8'h00);
    for (int r = 0; r < 2; r++) begin
      period = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        period++;
        if (frame_pulse) break;
      end
      checks++;
      if (period != FR) begin errors++; $display("FAIL pulse_period: got %0d clk required %0d", period, FR); end
    end
    sh8 = '0;
    push_frames(2, sh8);
    check_frames(2);
  endtask

  task automatic test_static();
    wait_pulse(1'b0, 8'h00);
    @(negedge clk);
    wr8(3'd0, 4'd4);
    wr8(3'd7, 4'd15);
    sh8[0] = 4'd4;
    sh8[7] = 4'd15;
    wait_pulse(1'b1, 8'h00);
    push_frames(2, sh8);
    check_frames(2);
  endtask

  task automatic test_rewrite();
    wait_pulse(1'b0, 8'h00);
    @(negedge clk);
    wr8(3'd3, 4'd2);
    wr8(3'd3, 4'd9);
    sh8[3] = 4'd9;
    wait_pulse(1'b0, 8'h00);
    push_frames(1, sh8);
    check_frames(1);
  endtask

  task automatic test_out_of_range();
    use6 = 1'b1;
    d6 = '0;
    wait_pulse(1'b0, 8'h00);
    @(negedge clk);
    wr6(3'd7, 4'd15);
    wr6(3'd6, 4'd15);
    wr6(3'd2, 4'd5);
    d6[2] = 4'd5;
    wait_pulse(1'b0, 8'h00);
    push_frames(1, d6);
    check_frames(1);
    use6 = 1'b0;
  endtask

  task automatic test_chase();
    logic [7:0] e;
    wait_pulse(1'b0, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wr8(3'(i), 4'd15);
      sh8[i] = 4'd15;
    end
    mode = 2'd1;
    wait_pulse(1'b0, 8'h00);
    for (int f = 0; f < 9; f++) begin
      e = 8'(1 << (f % 8));
      for (int c = 0; c < FR; c++) exp_q.push_back(e);
    end
    check_frames(9);
  endtask

  task automatic test_breathe();
    logic [7:0][3:0] d;
    int duty;
    wait_pulse(1'b0, 8'h00);
    @(negedge clk);
    mode = 2'd2;
    wait_pulse(1'b0, 8'h00);
    for (int f = 0; f < 32; f++) begin
      duty = (f <= 15) ? f : ((f <= 30) ? 30 - f : 1);
      for (int i = 0; i < 8; i++) d[i] = 4'(duty);
      push_frames(1, d);
    end
    check_frames(32);
  endtask

  task automatic test_reset_mid();
    mode = 2'd1;
    wait_pulse(1'b0, 8'h00);
    repeat (5) @(negedge clk);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL chase_before_reset: led=%h required 01", led); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL mid_reset_led: led=%h required 00", led); end
    checks++;
    if (frame_pulse !== 1'b0) begin errors++; $display("FAIL mid_reset_pulse: frame_pulse=%b required 0", frame_pulse); end
    reset = 1'b0;
    mode = 2'd0;
    wr8(3'd1, 4'd6);
    wait_pulse(1'b1, 8'h00);
    sh8 = '0;
    sh8[1] = 4'd6;
    push_frames(1, sh8);
    check_frames(1);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; mode = 2'd0;
    wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0; mode6 = 2'd0;
    sh8 = '0;
    d6 = '0;
    test_reset();
    test_static();
    test_rewrite();
    test_out_of_range();
    test_chase();
    test_breathe();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
